// File: rtl/exec_alu_cc.sv
// Y86-64 SEQ execute stage: ALU, condition codes, branch condition and machine status.
// Optional instruction counter output icount_o enabled by defining EXEC_ICOUNT_EN.
module exec_alu_cc #(
    parameter int          DATA_W = 64,
    parameter logic [2:0]  CC_RST = 3'b100
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [3:0]        icode_i,
    input  logic [3:0]        ifun_i,
    input  logic [DATA_W-1:0] valA_i,
    input  logic [DATA_W-1:0] valB_i,
    input  logic [DATA_W-1:0] valC_i,
    output logic [DATA_W-1:0] valE_o,
    output logic              Cnd_o,
    output logic [2:0]        cc_o,
    output logic [2:0]        stat_o
`ifdef EXEC_ICOUNT_EN
    ,
    output logic [31:0]       icount_o
`endif
);

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVQ  = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [DATA_W-1:0] STACK_STEP = DATA_W'(8);

    // State encoding equals the stat_o code so the status output is the state flop itself.
    typedef enum logic [2:0] {
        ST_RUN = 3'b001,
        ST_HLT = 3'b010,
        ST_INS = 3'b100
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cc_q, cc_d;
    logic [DATA_W-1:0] alu_res;
    logic              alu_of;
    logic              is_run;
    logic              zf, sf, of;
    logic              cnd_raw;

    assign is_run = (state_q == ST_RUN);
    assign zf     = cc_q[2];
    assign sf     = cc_q[1];
    assign of     = cc_q[0];

    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        unique case (icode_i)
            I_CMOVQ:            alu_res = valA_i;
            I_IRMOVQ:           alu_res = valC_i;
            I_RMMOVQ, I_MRMOVQ: alu_res = valB_i + valC_i;
            I_CALL, I_PUSHQ:    alu_res = valB_i - STACK_STEP;
            I_RET, I_POPQ:      alu_res = valB_i + STACK_STEP;
            I_OPQ: begin
                unique case (ifun_i)
                    4'h0: begin
                        alu_res = valB_i + valA_i;
                        alu_of  = (valA_i[DATA_W-1] == valB_i[DATA_W-1]) &&
                                  (alu_res[DATA_W-1] != valA_i[DATA_W-1]);
                    end
                    4'h1: begin
                        alu_res = valB_i - valA_i;
                        alu_of  = (valA_i[DATA_W-1] != valB_i[DATA_W-1]) &&
                                  (alu_res[DATA_W-1] != valB_i[DATA_W-1]);
                    end
                    4'h2:    alu_res = valB_i & valA_i;
                    4'h3:    alu_res = valB_i ^ valA_i;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // Condition is evaluated on the CC as registered before this instruction's update.
    always_comb begin
        cnd_raw = 1'b0;
        if (icode_i == I_CMOVQ || icode_i == I_JXX) begin
            unique case (ifun_i)
                4'h0:    cnd_raw = 1'b1;
                4'h1:    cnd_raw = (sf ^ of) | zf;
                4'h2:    cnd_raw = sf ^ of;
                4'h3:    cnd_raw = zf;
                4'h4:    cnd_raw = ~zf;
                4'h5:    cnd_raw = ~(sf ^ of);
                4'h6:    cnd_raw = ~(sf ^ of) & ~zf;
                default: cnd_raw = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cc_d    = cc_q;
        if (is_run && valid_i) begin
            if (icode_i == I_HALT) begin
                state_d = ST_HLT;
            end else if (icode_i > I_POPQ || (icode_i == I_OPQ && ifun_i > 4'h3)) begin
                state_d = ST_INS;
            end else if (icode_i == I_OPQ) begin
                cc_d = {(alu_res == '0), alu_res[DATA_W-1], alu_of};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            cc_q    <= CC_RST;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
        end
    end

    assign valE_o = is_run ? alu_res : '0;
    assign Cnd_o  = is_run & cnd_raw;
    assign cc_o   = cc_q;
    assign stat_o = state_q;

`ifdef EXEC_ICOUNT_EN
    logic [31:0] icount_q, icount_d;

    // The HALT instruction itself is counted; nothing counts once stopped.
    always_comb begin
        icount_d = icount_q;
        if (is_run && valid_i) begin
            icount_d = icount_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            icount_q <= '0;
        end else begin
            icount_q <= icount_d;
        end
    end

    assign icount_o = icount_q;
`endif

    logic unused_nop;
    assign unused_nop = (I_NOP == 4'h1);

endmodule

// File: tb/tb_exec_alu_cc.sv
// Scoreboard bench for exec_alu_cc: driver queues expected outputs, negedge monitor compares.
module tb_exec_alu_cc;

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [3:0]  icode_i = 4'h1;
    logic [3:0]  ifun_i = 4'h0;
    logic [63:0] valA_i = '0;
    logic [63:0] valB_i = '0;
    logic [63:0] valC_i = '0;
    logic [63:0] valE_o;
    logic        Cnd_o;
    logic [2:0]  cc_o;
    logic [2:0]  stat_o;
`ifdef EXEC_ICOUNT_EN
    logic [31:0] icount_o;
`endif

    exec_alu_cc dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .icode_i (icode_i),
        .ifun_i  (ifun_i),
        .valA_i  (valA_i),
        .valB_i  (valB_i),
        .valC_i  (valC_i),
        .valE_o  (valE_o),
        .Cnd_o   (Cnd_o),
        .cc_o    (cc_o),
        .stat_o  (stat_o)
`ifdef EXEC_ICOUNT_EN
        ,
        .icount_o(icount_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          id;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] e;
        logic        chk_e;
        logic        cnd;
        logic [2:0]  cc;
        logic [2:0]  stat;
        int          ic;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_issued = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic v, input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [63:0] e, input logic chk_e, input logic cnd,
                         input logic [2:0] cc, input logic [2:0] stat, input int ic);
        exp_t x;
        @(posedge clk_i);
        #1;
        valid_i = v; icode_i = icode; ifun_i = ifun;
        valA_i = a; valB_i = b; valC_i = c;
        x.id = n_issued; x.icode = icode; x.ifun = ifun;
        x.e = e; x.chk_e = chk_e; x.cnd = cnd; x.cc = cc; x.stat = stat; x.ic = ic;
        sb.push_back(x);
        n_issued++;
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1; valid_i = 1'b0; icode_i = 4'h1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            $display("txn %0d icode=%0h ifun=%0h valE=0x%0h Cnd=%0b cc=%03b stat=%0d",
                     x.id, x.icode, x.ifun, valE_o, Cnd_o, cc_o, stat_o);
            if (x.chk_e) check($sformatf("valE[%0d]", x.id), valE_o, x.e);
            check($sformatf("Cnd[%0d]", x.id), {63'd0, Cnd_o}, {63'd0, x.cnd});
            check($sformatf("cc[%0d]", x.id), {61'd0, cc_o}, {61'd0, x.cc});
            check($sformatf("stat[%0d]", x.id), {61'd0, stat_o}, {61'd0, x.stat});
`ifdef EXEC_ICOUNT_EN
            if (x.ic >= 0) check($sformatf("icount[%0d]", x.id), {32'd0, icount_o}, 64'(x.ic));
`endif
        end
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        //     v  ic  fn  valA  valB   valC   valE                chk cnd cc      stat ic
        issue(1, 6, 0, 64'd1, ALL1,  0,     64'd0,              1, 0, 3'b100, 1, -1);
        issue(1, 6, 0, MAXP,  MAXP,  0,     64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 3'b100, 1, -1);
        issue(1, 7, 2, 0,     0,     0,     64'd0,              1, 0, 3'b011, 1, -1);
        issue(1, 7, 1, 0,     0,     0,     64'd0,              1, 0, 3'b011, 1, -1);
        issue(1, 7, 0, 0,     0,     0,     64'd0,              1, 1, 3'b011, 1, -1);
        issue(1, 6, 1, 64'd7, 64'd5, 0,     64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 3'b011, 1, -1);
        issue(1, 2, 2, 64'h42, 0,    0,     64'h42,             1, 1, 3'b010, 1, -1);
        issue(1, 7, 3, 0,     0,     0,     64'd0,              1, 0, 3'b010, 1, -1);
        issue(1, 7, 4, 0,     0,     0,     64'd0,              1, 1, 3'b010, 1, -1);
        issue(1, 7, 5, 0,     0,     0,     64'd0,              1, 0, 3'b010, 1, -1);
        issue(1, 7, 6, 0,     0,     0,     64'd0,              1, 0, 3'b010, 1, -1);
        issue(1, 4'hA, 0, 0,  64'h100, 0,   64'hF8,             1, 0, 3'b010, 1, -1);
        issue(1, 4'hB, 0, 0,  64'hF8, 0,    64'h100,            1, 0, 3'b010, 1, -1);
        issue(1, 4, 0, 0,     64'h10, 64'h8, 64'h18,            1, 0, 3'b010, 1, -1);
        issue(1, 5, 0, 0,     64'h20, 64'hFFFF_FFFF_FFFF_FFF8, 64'h18, 1, 0, 3'b010, 1, -1);
        issue(1, 8, 0, 0,     64'h20, 0,    64'h18,             1, 0, 3'b010, 1, -1);
        issue(1, 9, 0, 0,     64'h18, 0,    64'h20,             1, 0, 3'b010, 1, -1);
        issue(1, 3, 0, 0,     0,     64'h55, 64'h55,            1, 0, 3'b010, 1, -1);
        issue(1, 1, 0, 0,     0,     0,     64'd0,              1, 0, 3'b010, 1, -1);
        issue(1, 2, 7, 64'h9, 0,     0,     64'h9,              1, 0, 3'b010, 1, -1);
        issue(1, 6, 2, 64'h0F, 64'hF0, 0,   64'd0,              1, 0, 3'b010, 1, -1);
        issue(1, 6, 3, 64'h0F, 64'hFF, 0,   64'hF0,             1, 0, 3'b100, 1, -1);
        issue(1, 6, 1, 64'd1, MINN,  0,     MAXP,               1, 0, 3'b000, 1, -1);
        issue(1, 7, 2, 0,     0,     0,     64'd0,              1, 1, 3'b001, 1, -1);
        issue(0, 6, 1, 64'd1, 64'd1, 0,     64'd0,              1, 0, 3'b001, 1, -1);
        issue(1, 6, 1, 64'd1, 64'd1, 0,     64'd0,              1, 0, 3'b001, 1, -1);
        issue(1, 6, 5, 64'd1, 64'd1, 0,     64'd0,              0, 0, 3'b100, 1, -1);
        issue(1, 6, 0, 64'd1, 64'd1, 0,     64'd0,              1, 0, 3'b100, 4, -1);
        issue(1, 7, 0, 0,     0,     0,     64'd0,              1, 0, 3'b100, 4, -1);
        do_reset();
        issue(0, 0, 0, 0,     0,     0,     64'd0,              1, 0, 3'b100, 1, 0);
        issue(1, 1, 0, 0,     0,     0,     64'd0,              1, 0, 3'b100, 1, 0);
        issue(1, 1, 0, 0,     0,     0,     64'd0,              1, 0, 3'b100, 1, 1);
        issue(1, 3, 0, 0,     0,     64'h7, 64'h7,              1, 0, 3'b100, 1, 2);
        issue(1, 0, 0, 0,     0,     0,     64'd0,              1, 0, 3'b100, 1, 3);
        issue(1, 1, 0, 0,     0,     0,     64'd0,              1, 0, 3'b100, 2, 4);
        issue(1, 7, 0, 0,     0,     0,     64'd0,              1, 0, 3'b100, 2, 4);
        issue(1, 6, 0, 64'd3, 64'd4, 0,     64'd0,              1, 0, 3'b100, 2, 4);
        repeat (3) @(posedge clk_i);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
